// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit and the iterative multiply/divide unit.
interface muldiv_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    // Control unit side: launches operations and watches busy/done.
    modport master (
        output start,
        output op,
        output op_a,
        output op_b,
        input  busy,
        input  done,
        input  result
    );

    // Execution unit side.
    modport slave (
        input  start,
        input  op,
        input  op_a,
        input  op_b,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// One bit per clock through a single shared adder/subtractor; a division
// by zero skips iteration and completes on the next cycle.
module muldiv_sequencer #(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state;
    logic                    busy_r;
    logic                    done_r;
    logic [DATA_WIDTH-1:0]   result_r;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [1:0]              op_r;
    logic [DATA_WIDTH-1:0]   b_r;
    logic [2*DATA_WIDTH-1:0] prod_r;
    logic [DATA_WIDTH:0]     rem_r;
    logic [DATA_WIDTH-1:0]   quo_r;

    logic [DATA_WIDTH+1:0]   add_x;
    logic [DATA_WIDTH+1:0]   add_y;
    logic [DATA_WIDTH+1:0]   add_sum;
    logic                    add_cin;
    logic [DATA_WIDTH:0]     rem_shift;
    logic [2*DATA_WIDTH-1:0] prod_next;
    logic [DATA_WIDTH:0]     rem_next;
    logic [DATA_WIDTH-1:0]   quo_next;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

    // Result selection once the last iteration's register values are known.
    function automatic logic [DATA_WIDTH-1:0] pick_result(
        input logic [1:0]            sel,
        input logic [2*DATA_WIDTH-1:0] prod,
        input logic [DATA_WIDTH-1:0] quo,
        input logic [DATA_WIDTH:0]   rem
    );
        logic [DATA_WIDTH-1:0] r;
        case (sel)
            2'b00:   r = prod[DATA_WIDTH-1:0];
            2'b01:   r = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            2'b10:   r = quo;
            2'b11:   r = rem[DATA_WIDTH-1:0];
            default: r = {DATA_WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Shared adder and next-iteration values for both algorithms.
    always_comb begin
        prod_next = prod_r;
        rem_next  = rem_r;
        quo_next  = quo_r;
        rem_shift = {rem_r[DATA_WIDTH-1:0], quo_r[DATA_WIDTH-1]};
        if (op_r[1]) begin
            // Trial subtraction of the divisor from the shifted remainder;
            // the top bit of the sum is the borrow (negative result).
            add_x   = {rem_r, quo_r[DATA_WIDTH-1]};
            add_y   = ~{2'b00, b_r};
            add_cin = 1'b1;
        end else begin
            // Multiplier adds the multiplicand into the upper product half.
            add_x   = {2'b00, prod_r[2*DATA_WIDTH-1:DATA_WIDTH]};
            add_y   = {2'b00, b_r};
            add_cin = 1'b0;
        end
        add_sum = add_x + add_y + {{(DATA_WIDTH+1){1'b0}}, add_cin};
        if (op_r[1]) begin
            if (!add_sum[DATA_WIDTH+1]) begin
                rem_next = add_sum[DATA_WIDTH:0];
                quo_next = {quo_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_next = rem_shift;
                quo_next = {quo_r[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            if (prod_r[0]) begin
                prod_next = {add_sum[DATA_WIDTH:0], prod_r[DATA_WIDTH-1:1]};
            end else begin
                prod_next = {1'b0, prod_r[2*DATA_WIDTH-1:1]};
            end
        end
    end

    // Sequencer FSM with registered busy/done/result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {DATA_WIDTH{1'b0}};
            cnt      <= {CNT_WIDTH{1'b0}};
            op_r     <= 2'b00;
            b_r      <= {DATA_WIDTH{1'b0}};
            prod_r   <= {(2*DATA_WIDTH){1'b0}};
            rem_r    <= {(DATA_WIDTH+1){1'b0}};
            quo_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_r   <= bus.op;
                        b_r    <= bus.op_b;
                        prod_r <= {{DATA_WIDTH{1'b0}}, bus.op_a};
                        rem_r  <= {(DATA_WIDTH+1){1'b0}};
                        quo_r  <= bus.op_a;
                        cnt    <= {CNT_WIDTH{1'b0}};
                        if (bus.op[1] && (bus.op_b == {DATA_WIDTH{1'b0}})) begin
                            // Divide by zero: quotient all ones, remainder is the dividend.
                            state    <= DONE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            result_r <= bus.op[0] ? bus.op_a : {DATA_WIDTH{1'b1}};
                        end else begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                            done_r <= 1'b0;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                CALC: begin
                    prod_r <= prod_next;
                    rem_r  <= rem_next;
                    quo_r  <= quo_next;
                    cnt    <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    if (cnt == LAST_CNT) begin
                        state    <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= pick_result(op_r, prod_next, quo_next, rem_next);
                    end else begin
                        state  <= CALC;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer against an arithmetic reference.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    muldiv_sequencer_if #(.DATA_WIDTH(W)) bus ();

    muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic with RISC-V divide-by-zero rules.
    function automatic logic [W-1:0] ref_model(input logic [1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'b00:   r = p[W-1:0];
            2'b01:   r = p[2*W-1:W];
            2'b10:   r = (b == 0) ? {W{1'b1}} : a / b;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation in the current cycle and follow it to its done cycle.
    // spam=1 keeps hammering start with fresh operands while busy.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit spam);
        logic [W-1:0] exp;
        bit fast;
        exp  = ref_model(op, a, b);
        fast = op[1] && (b == 0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        step();
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        if (!fast) begin
            for (int i = 1; i <= W; i++) begin
                chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
                chk({tag, "_nodone"}, {31'b0, bus.done}, 32'd0);
                bus.start = spam;
                bus.op    = 2'($urandom_range(0, 3));
                bus.op_a  = $urandom;
                bus.op_b  = $urandom;
                step();
            end
            bus.start = 1'b0;
        end
        chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        chk({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "_result"}, bus.result, exp);
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.op_a  = '0;
        bus.op_b  = '0;
        step();
        step();
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        rst = 1'b0;
        step();

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 1'b0);
        step();
        chk("mul_hold_done", {31'b0, bus.done}, 32'd0);
        chk("mul_hold_result", bus.result, 32'd42);
        step();
        chk("mul_hold_result2", bus.result, 32'd42);

        run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step();
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step();
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b0);
        step();
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        step();
        run_op("divu_5_9", 2'b10, 32'd5, 32'd9, 1'b0);
        step();
        run_op("remu_5_9", 2'b11, 32'd5, 32'd9, 1'b0);
        step();
        run_op("divu_by0", 2'b10, 32'd1234, 32'd0, 1'b0);
        step();
        chk("divu_by0_after", {31'b0, bus.done}, 32'd0);
        run_op("remu_by0", 2'b11, 32'd1234, 32'd0, 1'b0);
        step();

        // Start hammered while busy, then back-to-back issue from the DONE cycle.
        run_op("spam_mul", 2'b00, 32'd123456, 32'd789, 1'b1);
        run_op("b2b_divu", 2'b10, 32'hDEAD_BEEF, 32'd1000, 1'b0);
        run_op("b2b_by0", 2'b11, 32'd77, 32'd0, 1'b0);
        run_op("b2b_mulhu", 2'b01, 32'h8000_0001, 32'h0001_0003, 1'b0);
        step();
        chk("b2b_end_done", {31'b0, bus.done}, 32'd0);

        // Reset in the middle of a DIVU must abort without a done pulse.
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.op_a  = 32'd999;
        bus.op_b  = 32'd3;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("abort_no_done", {31'b0, bus.done}, 32'd0);
        end
        run_op("after_abort", 2'b10, 32'd999, 32'd3, 1'b0);
        step();

        // Randomized operations; some divisors forced small or zero.
        for (int k = 0; k < 24; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case (k % 4)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op("rand", rop, ra, rb, 1'(k % 3 == 0));
            if (k % 2 == 0) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
